fpu_norm_round: RTL and testbench
=================================

Name: fpu_norm_round

Overview:
- Multi-cycle normalise/round stage directly downstream of the FP adder; consumes its 34-bit raw sum {sign, exp[7:0], man[24:0]}.
- man[24] is the carry bit, man[23] the hidden bit; exponent field value 1 with man[23]=0 denotes a denormal.
- Produces a packed IEEE-754 single result plus status flags over a valid/ready handshake.
- Left-normalises iteratively, one bit per cycle; handles carry with round-to-nearest-even.

Parameters:
- EXP_W, 8, exponent width; only the default is supported.
- FRAC_W, 23, stored fraction width; only the default is supported; raw mantissa is FRAC_W+2 bits.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- valid_i  in  1  add_i/exception_i valid.
- ready_o  out  1  stage can accept.
- add_i  in  34  {sign, exp[7:0], man[24:0]} from adder.
- exception_i  in  3  special-case code from the unpack stage.
- valid_o  out  1  result_o/flags_o valid.
- ready_i  in  1  consumer accepts.
- result_o  out  32  {sign, exp[7:0], frac[22:0]}.
- flags_o  out  4  {overflow, underflow, zero, inexact}.

Behaviour:
- Reset (rst_i=1 at edge): state IDLE, valid_o=0, result_o=0, flags_o=0. ready_o=0 while rst_i=1.
- Reset mid-operation aborts and discards the in-flight operand.
- States: IDLE, EVAL, SHIFT, ROUND, DONE. ready_o=1 only in IDLE (not in reset).
- IDLE: on valid_i&&ready_o, register sign, exp, man, exception_i; go to EVAL. This is edge E0.
- EVAL (E1), first matching rule wins:
  - exception_i!=0: go to DONE with a special result.
    - 001: 0x7FC00000.
    - 010: {sign,8'hFF,23'h0}.
    - 011: {sign,31'h0}, zero flag set.
    - others: 0x7FC00000.
  - man==0: result 0x00000000 (+0 for exact cancellation), zero=1; go to DONE.
  - man[24]=1: go to ROUND.
  - man[23]=0 and exp>1: go to SHIFT.
  - else: go to DONE. Exponent field is exp if man[23]=1, else 0 (denormal, underflow=1).
- SHIFT: each cycle man<<=1 and exp-=1.
  - Leave to DONE on the edge where the new man[23]=1 or the new exp==1.
  - Exit exp==1 with man[23]=0 gives a denormal: exponent field 0, underflow=1.
  - Bound: at most 23 shifts, so no wrap and exp never goes below 1.
- ROUND (single cycle):
  - r=man[0]; man>>=1; exp+=1.
  - If r=1, it is always a tie, so round to even: increment man if the new lsb=1.
  - Set inexact=r.
  - If rounding carries into bit 24: shift right once more and exp+=1; that dropped bit is 0.
  - If final exp>=255: result {sign,8'hFF,23'h0}, overflow=1, inexact=1.
  - Go to DONE.
- DONE:
  - valid_o=1; result_o and flags_o held stable while ready_i=0.
  - On valid_o&&ready_i, go to IDLE and drop valid_o next cycle.
  - No acceptance in DONE; minimum 1 idle cycle between ops.
- Latency from E0 to valid_o high:
  - E1 for special, zero or already-normal results.
  - E2 for carry.
  - E(n+1) for n left shifts.
- Width rules: all exponent math is unsigned 9-bit internally to detect overflow; result_o frac = man[22:0].
- valid_i while not ready_o: ignored and not stored.

Test Plan:
- add_i={0,8'd127,25'h1000000}, exc=0: result_o=0x40000000, flags=0000, valid_o at E2.
- add_i={0,8'd127,25'h1000003}: tie-to-even increments; result_o=0x40000002, flags=0001, valid at E2.
- add_i={0,8'd127,25'h0000001}: 23 shifts; result_o=0x34000000, flags=0000, valid at E24.
  - Repeat with rst_i pulsed at E10: valid_o stays 0, back in IDLE with ready_o=1 after reset.
- add_i={1,8'd2,25'h0100000}: one shift to exp 1; result_o=0x80200000, flags=0100, valid at E2.
  - add_i={1,8'd5,25'h0}: result_o=0x00000000, flags=0010, valid at E1.
- add_i={0,8'd254,25'h1000000}: result_o=0x7F800000, flags=1001.
  - exception_i=3'b001 with any add_i: result_o=0x7FC00000 at E1.
- Backpressure: ready_i=0 for 5 cycles in DONE: valid_o, result_o and flags_o unchanged; ready_o=0.
  - A valid_i pulse during that window is dropped.
  - Release ready_i: IDLE next cycle and ready_o=1.

Source files
------------

// File: rtl/fpu_norm_round.sv
`default_nettype none
// ============================================================================
// fpu_norm_round : iterative normalise / round-to-nearest-even stage that
//                  follows the FP adder; emits packed single + status flags.
// Revision 1.0
// ============================================================================
module fpu_norm_round #(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 23
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      valid_i,
   output logic                      ready_o,
   input  logic [EXP_W+FRAC_W+2:0]   add_i,
   input  logic [2:0]                exception_i,
   output logic                      valid_o,
   input  logic                      ready_i,
   output logic [EXP_W+FRAC_W:0]     result_o,
   output logic [3:0]                flags_o
);

   localparam int MAN_W = FRAC_W + 2;
   localparam int XW    = EXP_W + 1;
   localparam int RES_W = EXP_W + FRAC_W + 1;

   localparam logic [XW-1:0]    EXP_ONE = XW'(1);
   localparam logic [XW-1:0]    EXP_MAX = XW'((1 << EXP_W) - 1);
   localparam logic [RES_W-1:0] QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_EVAL  = 3'd1;
   localparam logic [2:0] S_SHIFT = 3'd2;
   localparam logic [2:0] S_ROUND = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]       state_q,  state_d;
   logic             sign_q,   sign_d;
   logic [XW-1:0]    exp_q,    exp_d;
   logic [MAN_W-1:0] man_q,    man_d;
   logic [2:0]       exc_q,    exc_d;
   logic [RES_W-1:0] result_q, result_d;
   logic [3:0]       flags_q,  flags_d;

   logic             w_accept;
   logic             w_is_special;
   logic             w_is_zero;
   logic             w_carry;
   logic             w_hidden;
   logic             w_need_shift;
   logic [MAN_W-1:0] w_shl_man;
   logic [XW-1:0]    w_shl_exp;
   logic             w_shift_done;
   logic             w_rnd_bit;
   logic [MAN_W-1:0] w_rsh_man;
   logic [MAN_W-1:0] w_rinc_man;
   logic             w_rcarry;
   logic [XW-1:0]    w_rnd_exp;
   logic [FRAC_W-1:0] w_rnd_frac;
   logic             w_rnd_ovf;
   logic [RES_W-1:0] w_special_res;
   logic [3:0]       w_special_flags;

   assign w_accept     = valid_i && ready_o;

   assign w_is_special = (exc_q != 3'd0);
   assign w_is_zero    = (man_q == '0);
   assign w_carry      = man_q[MAN_W-1];
   assign w_hidden     = man_q[FRAC_W];
   assign w_need_shift = !w_hidden && (exp_q > EXP_ONE);

   // One left-normalisation step; stop once hidden bit appears or exponent floors at 1.
   assign w_shl_man    = {man_q[MAN_W-2:0], 1'b0};
   assign w_shl_exp    = exp_q - EXP_ONE;
   assign w_shift_done = w_shl_man[FRAC_W] || (w_shl_exp == EXP_ONE);

   // A dropped 1 is always exactly half an ulp, so only tie-to-even applies.
   assign w_rnd_bit  = man_q[0];
   assign w_rsh_man  = {1'b0, man_q[MAN_W-1:1]};
   assign w_rinc_man = w_rsh_man + MAN_W'(w_rnd_bit & w_rsh_man[0]);
   assign w_rcarry   = w_rinc_man[MAN_W-1];
   assign w_rnd_exp  = exp_q + (w_rcarry ? XW'(2) : XW'(1));
   assign w_rnd_frac = w_rcarry ? w_rinc_man[FRAC_W:1] : w_rinc_man[FRAC_W-1:0];
   assign w_rnd_ovf  = (w_rnd_exp >= EXP_MAX);

   always_comb begin
      w_special_res   = QNAN;
      w_special_flags = 4'b0000;
      case (exc_q)
         3'b001: w_special_res = QNAN;
         3'b010: w_special_res = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
         3'b011: begin
            w_special_res   = {sign_q, {(RES_W-1){1'b0}}};
            w_special_flags = 4'b0010;
         end
         default: w_special_res = QNAN;
      endcase
   end

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (w_accept) begin
               state_d = S_EVAL;
            end
         end
         S_EVAL: begin
            if (w_is_special || w_is_zero) begin
               state_d = S_DONE;
            end else if (w_carry) begin
               state_d = S_ROUND;
            end else if (w_need_shift) begin
               state_d = S_SHIFT;
            end else begin
               state_d = S_DONE;
            end
         end
         S_SHIFT: begin
            if (w_shift_done) begin
               state_d = S_DONE;
            end
         end
         S_ROUND: state_d = S_DONE;
         S_DONE: begin
            if (ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      ready_o  = (state_q == S_IDLE) && !rst_i;
      valid_o  = (state_q == S_DONE);
      result_o = result_q;
      flags_o  = flags_q;
   end

   // Datapath next values
   always_comb begin
      sign_d   = sign_q;
      exp_d    = exp_q;
      man_d    = man_q;
      exc_d    = exc_q;
      result_d = result_q;
      flags_d  = flags_q;
      case (state_q)
         S_IDLE: begin
            if (w_accept) begin
               sign_d  = add_i[EXP_W+MAN_W];
               exp_d   = {1'b0, add_i[EXP_W+MAN_W-1:MAN_W]};
               man_d   = add_i[MAN_W-1:0];
               exc_d   = exception_i;
               flags_d = 4'b0000;
            end
         end
         S_EVAL: begin
            if (w_is_special) begin
               result_d = w_special_res;
               flags_d  = w_special_flags;
            end else if (w_is_zero) begin
               result_d = '0;
               flags_d  = 4'b0010;
            end else if (!w_carry && !w_need_shift) begin
               result_d = {sign_q, (w_hidden ? exp_q[EXP_W-1:0] : {EXP_W{1'b0}}),
                           man_q[FRAC_W-1:0]};
               flags_d  = {1'b0, !w_hidden, 2'b00};
            end
         end
         S_SHIFT: begin
            man_d = w_shl_man;
            exp_d = w_shl_exp;
            if (w_shift_done) begin
               result_d = {sign_q, (w_shl_man[FRAC_W] ? w_shl_exp[EXP_W-1:0] : {EXP_W{1'b0}}),
                           w_shl_man[FRAC_W-1:0]};
               flags_d  = {1'b0, !w_shl_man[FRAC_W], 2'b00};
            end
         end
         S_ROUND: begin
            exp_d = w_rnd_exp;
            if (w_rnd_ovf) begin
               result_d = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
               flags_d  = 4'b1001;
            end else begin
               result_d = {sign_q, w_rnd_exp[EXP_W-1:0], w_rnd_frac};
               flags_d  = {3'b000, w_rnd_bit};
            end
         end
         default: begin
            result_d = result_q;
         end
      endcase
   end

   // Datapath registers; reset also discards any in-flight operand.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sign_q   <= 1'b0;
         exp_q    <= '0;
         man_q    <= '0;
         exc_q    <= 3'd0;
         result_q <= '0;
         flags_q  <= 4'b0000;
      end else begin
         sign_q   <= sign_d;
         exp_q    <= exp_d;
         man_q    <= man_d;
         exc_q    <= exc_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fpu_norm_round.sv
`default_nettype none
// Scoreboard bench for fpu_norm_round: directed vectors with hand-computed
// results, flags and E0-to-valid latency.
module tb_fpu_norm_round;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        valid_i;
   logic        ready_o;
   logic [33:0] add_i;
   logic [2:0]  exception_i;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] result_o;
   logic [3:0]  flags_o;

   fpu_norm_round #(.EXP_W(8), .FRAC_W(23)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .add_i       (add_i),
      .exception_i (exception_i),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .result_o    (result_o),
      .flags_o     (flags_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  fl;
      int          lat;
      int          c0;
   } exp_t;

   exp_t sb[$];
   exp_t mon_x;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   logic mon_prev = 1'b0;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: one scoreboard entry per rising valid_o.
   always @(negedge clk_i) begin
      if (valid_o && !mon_prev) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid: got result 0x%08h with no pending op", result_o);
         end else begin
            mon_x = sb.pop_front();
            chk("result", result_o, mon_x.res);
            chk("flags", {28'd0, flags_o}, {28'd0, mon_x.fl});
            chk("latency", cyc - mon_x.c0 - 1, mon_x.lat);
         end
      end
      mon_prev = valid_o;
   end

   // Called at a negedge; E0 is the following posedge.
   task automatic issue(input logic [33:0] a, input logic [2:0] e, input logic [31:0] r,
                        input logic [3:0] f, input int lat, input bit expect_out);
      int n = 0;
      while (!ready_o && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      if (!ready_o) begin
         total++;
         bad++;
         $display("FAIL ready_wait: ready_o got 0 expected 1 within 200 cycles");
         return;
      end
      add_i       = a;
      exception_i = e;
      valid_i     = 1'b1;
      if (expect_out) sb.push_back('{r, f, lat, cyc});
      @(negedge clk_i);
      valid_i = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation got stuck, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      rst_i       = 1'b1;
      valid_i     = 1'b0;
      ready_i     = 1'b1;
      add_i       = '0;
      exception_i = 3'd0;
      repeat (3) @(negedge clk_i);
      chk("rst_ready", {31'd0, ready_o}, 32'd0);
      chk("rst_valid", {31'd0, valid_o}, 32'd0);
      chk("rst_result", result_o, 32'h0);
      chk("rst_flags", {28'd0, flags_o}, 32'd0);
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("idle_ready", {31'd0, ready_o}, 32'd1);

      // Carry / round paths
      issue({1'b0, 8'd127, 25'h1000000}, 3'd0, 32'h40000000, 4'b0000, 2, 1);
      issue({1'b0, 8'd127, 25'h1000003}, 3'd0, 32'h40000002, 4'b0001, 2, 1);
      issue({1'b0, 8'd127, 25'h1000001}, 3'd0, 32'h40000000, 4'b0001, 2, 1);
      issue({1'b0, 8'd127, 25'h1FFFFFF}, 3'd0, 32'h40800000, 4'b0001, 2, 1);
      issue({1'b0, 8'd254, 25'h1000000}, 3'd0, 32'h7F800000, 4'b1001, 2, 1);
      issue({1'b0, 8'd253, 25'h1FFFFFF}, 3'd0, 32'h7F800000, 4'b1001, 2, 1);
      // Shift paths
      issue({1'b0, 8'd127, 25'h0000001}, 3'd0, 32'h34000000, 4'b0000, 24, 1);
      issue({1'b1, 8'd2,   25'h0100000}, 3'd0, 32'h80200000, 4'b0100, 2, 1);
      issue({1'b1, 8'd10,  25'h0200000}, 3'd0, 32'h84000000, 4'b0000, 3, 1);
      // Direct EVAL results
      issue({1'b1, 8'd5,   25'h0000000}, 3'd0, 32'h00000000, 4'b0010, 1, 1);
      issue({1'b0, 8'd100, 25'h0800001}, 3'd0, 32'h32000001, 4'b0000, 1, 1);
      issue({1'b0, 8'd1,   25'h0400000}, 3'd0, 32'h00400000, 4'b0100, 1, 1);
      // Exceptions
      issue({1'b1, 8'h55,  25'h1234567}, 3'b001, 32'h7FC00000, 4'b0000, 1, 1);
      issue({1'b1, 8'd10,  25'h1000000}, 3'b010, 32'hFF800000, 4'b0000, 1, 1);
      issue({1'b1, 8'd10,  25'h0800000}, 3'b011, 32'h80000000, 4'b0010, 1, 1);
      issue({1'b0, 8'd10,  25'h0800000}, 3'b111, 32'h7FC00000, 4'b0000, 1, 1);

      // Reset at E10 of a 23-shift operation
      issue({1'b0, 8'd127, 25'h0000001}, 3'd0, 32'h0, 4'b0000, 0, 0);
      repeat (9) @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("abort_valid", {31'd0, valid_o}, 32'd0);
      chk("abort_ready_in_rst", {31'd0, ready_o}, 32'd0);
      chk("abort_result", result_o, 32'h0);
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("abort_ready", {31'd0, ready_o}, 32'd1);
      chk("abort_valid_after", {31'd0, valid_o}, 32'd0);
      repeat (30) @(negedge clk_i);

      // Backpressure in DONE with a dropped valid_i pulse
      ready_i = 1'b0;
      issue({1'b0, 8'd127, 25'h1000003}, 3'd0, 32'h40000002, 4'b0001, 2, 1);
      n = 0;
      while (!valid_o && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      for (int k = 0; k < 5; k++) begin
         chk("bp_valid", {31'd0, valid_o}, 32'd1);
         chk("bp_result", result_o, 32'h40000002);
         chk("bp_flags", {28'd0, flags_o}, 32'd1);
         chk("bp_ready", {31'd0, ready_o}, 32'd0);
         if (k == 2) begin
            add_i       = {1'b0, 8'd127, 25'h1000000};
            exception_i = 3'd0;
            valid_i     = 1'b1;
         end else begin
            valid_i = 1'b0;
         end
         @(negedge clk_i);
      end
      ready_i = 1'b1;
      @(negedge clk_i);
      chk("bp_release_valid", {31'd0, valid_o}, 32'd0);
      chk("bp_release_ready", {31'd0, ready_o}, 32'd1);
      repeat (20) @(negedge clk_i);

      chk("sb_empty", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
